// File: rtl/alu_control_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_control_md : EX-stage ALU control decode plus iterative MULTU/DIVU unit |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module alu_control_md #(
    parameter int WIDTH      = 32,
    parameter int DIV_ENABLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       ALUFunction,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [3:0]       ALUOperation,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_done
);

    localparam int   CW          = $clog2(WIDTH + 1);
    localparam logic DIV_EN      = (DIV_ENABLE != 0);
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor

    logic               is_multu, is_divu, start_mul, start_div, last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign is_multu  = (ALUOp == 3'b111) && (ALUFunction == F_MULTU);
    assign is_divu   = (ALUOp == 3'b111) && (ALUFunction == F_DIVU) && DIV_EN;
    assign start_mul = (state == IDLE) && valid && is_multu;
    assign start_div = (state == IDLE) && valid && is_divu;
    assign last_iter = (count == CW'(1));

    always_comb begin
        ALUOperation = 4'b1001;
        case (ALUOp)
            3'b111: begin
                case (ALUFunction)
                    6'b100100: ALUOperation = 4'b0000;
                    6'b100101: ALUOperation = 4'b0001;
                    6'b100111: ALUOperation = 4'b0010;
                    6'b100000: ALUOperation = 4'b0011;
                    6'b100010: ALUOperation = 4'b0100;
                    6'b101010: ALUOperation = 4'b0101;
                    6'b000000: ALUOperation = 4'b0110;
                    6'b000010: ALUOperation = 4'b0111;
                    6'b001000: ALUOperation = 4'b1000;
                    6'b010000: ALUOperation = 4'b1010;
                    6'b010010: ALUOperation = 4'b1011;
                    F_MULTU:   ALUOperation = 4'b1101;
                    F_DIVU:    ALUOperation = DIV_EN ? 4'b1101 : 4'b1001;
                    default:   ALUOperation = 4'b1001;
                endcase
            end
            3'b100:  ALUOperation = 4'b0011;
            3'b101:  ALUOperation = 4'b0001;
            3'b110:  ALUOperation = 4'b0000;
            3'b011:  ALUOperation = 4'b1100;
            default: ALUOperation = 4'b1001;
        endcase
    end

    // One shift-add step and one restoring-division step, evaluated every cycle.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, opnd});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH])
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        md_done    = 1'b0;
        case (state)
            IDLE: begin
                if (start_mul) begin
                    stall      = 1'b1;
                    state_next = MUL;
                end else if (start_div) begin
                    stall      = 1'b1;
                    state_next = DIV;
                end
            end
            MUL: begin
                stall = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DIV: begin
                stall = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                md_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        acc   <= {{WIDTH{1'b0}}, operand_b};
                        opnd  <= operand_a;
                        count <= CW'(WIDTH);
                    end else if (start_div) begin
                        acc   <= {{WIDTH{1'b0}}, operand_a};
                        opnd  <= operand_b;
                        count <= CW'(WIDTH);
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count - CW'(1);
                    if (last_iter) {hi, lo} <= mul_next;
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count - CW'(1);
                    if (last_iter) begin
                        hi <= div_next[2*WIDTH-1:WIDTH];
                        lo <= div_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_control_md : random and directed checks against a reference model    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_alu_control_md;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid, valid8;
    logic [2:0]  aluop, aluop8;
    logic [5:0]  funct, funct8;
    logic [31:0] a, b, hi32, lo32;
    logic [7:0]  a8, b8, hi8, lo8;
    logic [3:0]  op32, op8;
    logic        stall32, done32, stall8, done8;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_control_md #(.WIDTH(32), .DIV_ENABLE(1)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ALUOp(aluop), .ALUFunction(funct),
        .operand_a(a), .operand_b(b), .ALUOperation(op32), .stall(stall32),
        .hi(hi32), .lo(lo32), .md_done(done32)
    );

    alu_control_md #(.WIDTH(8), .DIV_ENABLE(0)) dut8 (
        .clk(clk), .reset(reset), .valid(valid8), .ALUOp(aluop8), .ALUFunction(funct8),
        .operand_a(a8), .operand_b(b8), .ALUOperation(op8), .stall(stall8),
        .hi(hi8), .lo(lo8), .md_done(done8)
    );

    function automatic logic [3:0] ref_op(input logic [2:0] o, input logic [5:0] f, input bit div_en);
        if (o == 3'b111) begin
            case (f)
                6'b100100: return 4'b0000;
                6'b100101: return 4'b0001;
                6'b100111: return 4'b0010;
                6'b100000: return 4'b0011;
                6'b100010: return 4'b0100;
                6'b101010: return 4'b0101;
                6'b000000: return 4'b0110;
                6'b000010: return 4'b0111;
                6'b001000: return 4'b1000;
                6'b010000: return 4'b1010;
                6'b010010: return 4'b1011;
                6'b011001: return 4'b1101;
                6'b011011: return div_en ? 4'b1101 : 4'b1001;
                default:   return 4'b1001;
            endcase
        end
        case (o)
            3'b100:  return 4'b0011;
            3'b101:  return 4'b0001;
            3'b110:  return 4'b0000;
            3'b011:  return 4'b1100;
            default: return 4'b1001;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; valid = 0; valid8 = 0;
        aluop = 0; funct = 0; a = 0; b = 0; aluop8 = 0; funct8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (stall32 !== 1'b0 || done32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
            mismatched++;
            $display("FAIL reset32: stall=%b done=%b hi=%h lo=%h, required 0 0 0 0", stall32, done32, hi32, lo32);
        end
        compared++;
        if (stall8 !== 1'b0 || done8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0) begin
            mismatched++;
            $display("FAIL reset8: stall=%b done=%b hi=%h lo=%h, required 0 0 0 0", stall8, done8, hi8, lo8);
        end
        reset = 1'b0;
    endtask

    task automatic test_decode();
        logic [8:0] listed [15];
        logic [3:0] e32, e8;
        listed = '{9'b111_100100, 9'b111_100101, 9'b111_100111, 9'b111_100000, 9'b111_100010,
                   9'b111_101010, 9'b111_000000, 9'b111_000010, 9'b111_001000, 9'b111_010000,
                   9'b111_010010, 9'b111_111111, 9'b000_000000, 9'b100_010101, 9'b011_111000};
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (i < 15) {aluop, funct} = listed[i];
            else {aluop, funct} = 9'($urandom());
            aluop8 = aluop; funct8 = funct;
            // MD starts are exercised elsewhere; the narrow unit has no DIVU, so it stays valid.
            valid  = !(aluop == 3'b111 && (funct == 6'b011001 || funct == 6'b011011));
            valid8 = !(aluop == 3'b111 && funct == 6'b011001);
            e32 = ref_op(aluop, funct, 1'b1);
            e8  = ref_op(aluop, funct, 1'b0);
            #1;
            compared++;
            if (op32 !== e32 || stall32 !== 1'b0) begin
                mismatched++;
                $display("FAIL decode32 op=%b f=%b: code=%b stall=%b, required %b 0", aluop, funct, op32, stall32, e32);
            end
            compared++;
            if (op8 !== e8 || stall8 !== 1'b0) begin
                mismatched++;
                $display("FAIL decode8 op=%b f=%b: code=%b stall=%b, required %b 0", aluop, funct, op8, stall8, e8);
            end
        end
        @(posedge clk); #1;
        valid = 0; valid8 = 0;
    endtask

    // Issues one MULTU/DIVU on the 32-bit unit with valid held through DONE, then an MFLO.
    task automatic do_md32(input bit is_div, input logic [31:0] x, input logic [31:0] y, input bit scramble);
        logic [31:0] eh, el;
        int n;
        if (!is_div) {eh, el} = 64'(x) * 64'(y);
        else if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
        else begin el = x / y; eh = x % y; end
        @(posedge clk); #1;
        valid = 1; aluop = 3'b111; funct = is_div ? 6'b011011 : 6'b011001; a = x; b = y;
        #1;
        n = 0;
        while (stall32 === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (scramble) begin a = 0; b = 0; end
            #1;
        end
        compared++;
        if (n != 33) begin
            mismatched++;
            $display("FAIL stall_len div=%0d a=%h b=%h: %0d cycles, required 33", is_div, x, y, n);
        end
        compared++;
        if (done32 !== 1'b1 || stall32 !== 1'b0 || hi32 !== eh || lo32 !== el) begin
            mismatched++;
            $display("FAIL result div=%0d a=%h b=%h: done=%b stall=%b hi=%h lo=%h, required 1 0 %h %h",
                     is_div, x, y, done32, stall32, hi32, lo32, eh, el);
        end
        @(posedge clk); #1;
        funct = 6'b010010;
        #1;
        compared++;
        if (op32 !== 4'b1011 || stall32 !== 1'b0 || done32 !== 1'b0 || hi32 !== eh || lo32 !== el) begin
            mismatched++;
            $display("FAIL after_done: code=%b stall=%b done=%b hi=%h lo=%h, required 1011 0 0 %h %h",
                     op32, stall32, done32, hi32, lo32, eh, el);
        end
        @(posedge clk); #1;
        valid = 0;
    endtask

    task automatic test_multu();
        do_md32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 4; i++) do_md32(1'b0, $urandom(), $urandom(), 1'b0);
    endtask

    task automatic test_divu();
        do_md32(1'b1, 32'd100, 32'd7, 1'b0);
        do_md32(1'b1, 32'd5, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) do_md32(1'b1, $urandom(), $urandom() >> $urandom_range(0, 31), 1'b0);
    endtask

    task automatic test_operand_change();
        do_md32(1'b0, 32'd3, 32'd5, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk); #1;
        valid = 1; aluop = 3'b111; funct = 6'b011011; a = 32'd1000; b = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        reset = 1; valid = 0;
        @(posedge clk); #1;
        compared++;
        if (stall32 !== 1'b0 || done32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_mid_op: stall=%b done=%b hi=%h lo=%h, required 0 0 0 0", stall32, done32, hi32, lo32);
        end
        reset = 0;
        @(posedge clk); #1;
        compared++;
        if (stall32 !== 1'b0 || done32 !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_idle: stall=%b done=%b, required 0 0", stall32, done32);
        end
        do_md32(1'b0, 32'd2, 32'd3, 1'b0);
    endtask

    task automatic test_narrow();
        logic [7:0] x, y, eh, el;
        int n;
        @(posedge clk); #1;
        valid8 = 1; aluop8 = 3'b111; funct8 = 6'b011011; a8 = 8'd100; b8 = 8'd7;
        for (int i = 0; i < 12; i++) begin
            #1;
            compared++;
            if (op8 !== 4'b1001 || stall8 !== 1'b0 || done8 !== 1'b0) begin
                mismatched++;
                $display("FAIL narrow_divu cyc %0d: code=%b stall=%b done=%b, required 1001 0 0", i, op8, stall8, done8);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin x = 8'hFF; y = 8'hFF; end
            else begin x = 8'($urandom()); y = 8'($urandom()); end
            {eh, el} = 16'(x) * 16'(y);
            @(posedge clk); #1;
            valid8 = 1; aluop8 = 3'b111; funct8 = 6'b011001; a8 = x; b8 = y;
            #1;
            n = 0;
            while (stall8 === 1'b1 && n < 50) begin
                n++;
                @(posedge clk); #2;
            end
            compared++;
            if (n != 9 || done8 !== 1'b1 || hi8 !== eh || lo8 !== el) begin
                mismatched++;
                $display("FAIL narrow_multu %h*%h: stall %0d cycles done=%b hi=%h lo=%h, required 9 1 %h %h",
                         x, y, n, done8, hi8, lo8, eh, el);
            end
            @(posedge clk); #1;
            valid8 = 0;
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_multu();
        test_divu();
        test_operand_change();
        test_reset_mid_op();
        test_narrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Next-generation ALU control for the MIPS EX stage.
- Combinationally decodes {ALUOp, ALUFunction} into a 4-bit ALUOperation code, with an extended R/I-type set.
- Adds a sequential multiply/divide sequencer: iterative unsigned MULTU/DIVU, HI/LO result registers, and a stall handshake that holds the pipeline until the result is written.

Parameters:
- WIDTH, 32: operand, HI and LO width; multicycle latency scales with it.
- DIV_ENABLE, 1: 1 = DIVU supported; 0 = DIVU decodes as illegal (4'b1001) and never starts.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  instruction in EX is valid.
- ALUOp  input  3  from main control unit.
- ALUFunction  input  6  instruction funct field.
- operand_a  input  WIDTH  rs value; multiplicand or dividend.
- operand_b  input  WIDTH  rt value; multiplier or divisor.
- ALUOperation  output  4  ALU operation code.
- stall  output  1  freeze PC, IF/ID and ID/EX while high.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- md_done  output  1  one-cycle pulse when HI/LO are written.

Behaviour:
- Decode is combinational and independent of state.
- R-type decode, ALUOp = 3'b111, funct -> ALUOperation:
  - AND 100100 -> 0000; OR 100101 -> 0001; NOR 100111 -> 0010
  - ADD 100000 -> 0011; SUB 100010 -> 0100; SLT 101010 -> 0101
  - SLL 000000 -> 0110; SRL 000010 -> 0111; JR 001000 -> 1000
  - MFHI 010000 -> 1010; MFLO 010010 -> 1011
  - MULTU 011001 -> 1101; DIVU 011011 -> 1101
- I-type decode, funct ignored: ADDI 3'b100 -> 0011; ORI 3'b101 -> 0001; ANDI 3'b110 -> 0000; LUI 3'b011 -> 1100.
- Any other combination -> 1001.
- The ALU treats 1101 as no-op/no writeback.
- Reset values: stall = 0, md_done = 0, hi = 0, lo = 0, FSM = IDLE, iteration counter = 0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - valid && MULTU: latch operands, set counter = WIDTH, go to MUL.
  - valid && DIVU && DIV_ENABLE: latch operands, set counter = WIDTH, go to DIV.
  - Otherwise stay in IDLE.
- stall is combinational. It is 1 in the issue cycle (IDLE && valid && start-op) and in every MUL/DIV cycle. It is 0 in IDLE otherwise and in DONE.
- MUL: shift-add on a 2*WIDTH product register, one multiplier bit per cycle. Counter decrements each cycle. When counter reaches 1, the edge writes {hi, lo} = product and moves to DONE.
- DIV: restoring division, one quotient bit per cycle, with the same counter rule. Final edge writes lo = quotient, hi = remainder and moves to DONE.
- DONE: md_done = 1, stall = 0, unconditional move to IDLE.
  - The still-held start instruction must not retrigger in DONE.
  - The pipeline advances on this edge.
- Latency: stall is high for exactly WIDTH+1 consecutive cycles (issue + WIDTH iterations). HI/LO are visible in the DONE cycle.
- Divide by zero: no special path. Result is lo = {WIDTH{1'b1}}, hi = operand_a, with the same latency.
- Operands are latched at issue. Changes on operand_a/operand_b during MUL/DIV have no effect.
- hi/lo hold their value except on the final iteration edge and on reset.
- MFHI/MFLO in the cycle directly after DONE return the new HI/LO.
- Reset during MUL/DIV/DONE: next edge goes to IDLE, hi = lo = 0, stall = 0, no md_done. The partial result is discarded.
- valid = 0 never starts an operation. Other decoded ops never affect FSM state.

Test Plan:
- Decode sweep: every listed {ALUOp, funct} pair plus ALUOp = 3'b111 with funct 111111 and ALUOp = 3'b000 -> exact codes above; 3'b111/111111 -> 1001; stall stays 0 for non-MD ops.
- MULTU, WIDTH = 32, a = 0xFFFFFFFF, b = 0xFFFFFFFF, valid held -> stall high 33 cycles, then md_done pulse; hi = 0xFFFFFFFE, lo = 0x00000001; no second start.
- DIVU a = 100, b = 7 -> lo = 14, hi = 2 after 33 stall cycles. DIVU a = 5, b = 0 -> lo = 0xFFFFFFFF, hi = 5.
- Operand change mid-op: MULTU 3 x 5, then a/b switched to 0 during MUL -> hi = 0, lo = 15. A following MFLO decodes 1011 with lo = 15.
- Reset asserted at iteration 10 of a DIVU -> stall = 0, hi = lo = 0, no md_done, FSM in IDLE next cycle; a fresh MULTU 2 x 3 -> lo = 6.
- DIV_ENABLE = 0, WIDTH = 8: DIVU -> ALUOperation = 1001, stall never asserts. MULTU 0xFF x 0xFF -> stall 9 cycles, hi = 0xFE, lo = 0x01.
